// File: rtl/mandel_sched.sv
// mandel_sched: iteration scheduler for a fixed-latency, non-stallable
// Mandelbrot single-step datapath. A metadata ring runs in lockstep with
// the datapath; each returning slot is either retired, re-issued for
// another iteration, parked while the output is busy, or replaced by a
// new pixel.
module mandel_sched #(
    parameter int LATENCY  = 30,
    parameter int MAX_ITER = 255,
    parameter int ITER_W   = 8,
    parameter int TAG_W    = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_x0,
    input  logic [31:0]       in_y0,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [31:0]       dp_x0,
    output logic [31:0]       dp_y0,
    output logic [31:0]       dp_xn,
    output logic [31:0]       dp_yn,
    input  logic [31:0]       dp_xn1,
    input  logic [31:0]       dp_yn1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TAG_W-1:0]  out_tag,
    output logic [ITER_W-1:0] out_iter,
    output logic              busy
);

    // Slot ring: index 0 is the head written by this cycle's issue,
    // index LATENCY-1 is the slot whose datapath result is returning now.
    logic [LATENCY-1:0] ring_vld;
    logic [LATENCY-1:0] ring_done;
    logic [TAG_W-1:0]   ring_tag  [LATENCY];
    logic [ITER_W-1:0]  ring_iter [LATENCY];
    logic [31:0]        ring_x0   [LATENCY];
    logic [31:0]        ring_y0   [LATENCY];

    logic              tail_vld;
    logic              tail_done;
    logic [ITER_W-1:0] iter_inc;
    logic [ITER_W-1:0] fin_iter;
    logic              escape;
    logic              finishing;
    logic              retire_ready;
    logic              out_free;
    logic              complete;
    logic              slot_free;

    logic              issue_vld;
    logic              issue_done;
    logic [TAG_W-1:0]  issue_tag;
    logic [ITER_W-1:0] issue_iter;
    logic [31:0]       issue_x0;
    logic [31:0]       issue_y0;
    logic [31:0]       issue_xn;
    logic [31:0]       issue_yn;

    // Escape needs only the exponent field: >= 0x80 means |v| >= 2, Inf or NaN.
    always_comb begin
        tail_vld     = ring_vld[LATENCY-1];
        tail_done    = ring_done[LATENCY-1];
        iter_inc     = ring_iter[LATENCY-1] + 1'b1;
        escape       = (dp_xn1[30:23] >= 8'h80) || (dp_yn1[30:23] >= 8'h80);
        finishing    = tail_vld && !tail_done &&
                       (escape || (iter_inc == ITER_W'(MAX_ITER)));
        retire_ready = tail_vld && (tail_done || finishing);
        fin_iter     = tail_done ? ring_iter[LATENCY-1] : iter_inc;
        out_free     = !out_valid || out_ready;
        complete     = retire_ready && out_free;
        slot_free    = !tail_vld || complete;
        in_ready     = slot_free;
        busy         = (|ring_vld) || out_valid;
    end

    // Decide what enters the ring head: new pixel, bubble, parked result or next iteration.
    always_comb begin
        issue_vld  = 1'b0;
        issue_done = 1'b0;
        issue_tag  = ring_tag[LATENCY-1];
        issue_iter = iter_inc;
        issue_x0   = ring_x0[LATENCY-1];
        issue_y0   = ring_y0[LATENCY-1];
        issue_xn   = dp_xn1;
        issue_yn   = dp_yn1;
        if (slot_free) begin
            issue_xn = 32'h0;
            issue_yn = 32'h0;
            if (in_valid) begin
                issue_vld  = 1'b1;
                issue_tag  = in_tag;
                issue_iter = '0;
                issue_x0   = in_x0;
                issue_y0   = in_y0;
            end
        end else if (retire_ready) begin
            // Parked: operands are irrelevant, feed zeros to keep the datapath quiet.
            issue_vld  = 1'b1;
            issue_done = 1'b1;
            issue_iter = fin_iter;
            issue_xn   = 32'h0;
            issue_yn   = 32'h0;
        end else begin
            issue_vld  = 1'b1;
        end
    end

    // Control state, datapath operand registers and the output register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ring_vld  <= '0;
            ring_done <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_iter  <= '0;
            dp_x0     <= 32'h0;
            dp_y0     <= 32'h0;
            dp_xn     <= 32'h0;
            dp_yn     <= 32'h0;
        end else begin
            ring_vld  <= {ring_vld[LATENCY-2:0], issue_vld};
            ring_done <= {ring_done[LATENCY-2:0], issue_done};
            dp_x0     <= issue_x0;
            dp_y0     <= issue_y0;
            dp_xn     <= issue_xn;
            dp_yn     <= issue_yn;
            if (complete) begin
                out_valid <= 1'b1;
                out_tag   <= ring_tag[LATENCY-1];
                out_iter  <= fin_iter;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Slot payload shifts with the ring; validity alone decides whether it matters.
    always_ff @(posedge clock) begin
        ring_tag[0]  <= issue_tag;
        ring_iter[0] <= issue_iter;
        ring_x0[0]   <= issue_x0;
        ring_y0[0]   <= issue_y0;
        for (int i = 1; i < LATENCY; i++) begin
            ring_tag[i]  <= ring_tag[i-1];
            ring_iter[i] <= ring_iter[i-1];
            ring_x0[i]   <= ring_x0[i-1];
            ring_y0[i]   <= ring_y0[i-1];
        end
    end

endmodule

// File: tb/tb_mandel_sched.sv
// Bench for mandel_sched: a behavioural float datapath with the same
// latency feeds results back; a scoreboard holds expected (tag, count)
// pairs and retires them in whatever order the scheduler emits them.
module tb_mandel_sched;
    localparam int LATENCY  = 30;
    localparam int MAX_ITER = 255;
    localparam int ITER_W   = 8;
    localparam int TAG_W    = 16;
    localparam int BUDGET   = 1000;

    logic              clock = 1'b0;
    logic              rst_n = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_x0 = '0, in_y0 = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic [31:0]       dp_x0, dp_y0, dp_xn, dp_yn, dp_xn1, dp_yn1;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [TAG_W-1:0]  out_tag;
    logic [ITER_W-1:0] out_iter;
    logic              busy;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               iter;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc_cyc[40];

    mandel_sched #(.LATENCY(LATENCY), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W), .TAG_W(TAG_W)) dut (
        .clock(clock), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x0(in_x0), .in_y0(in_y0), .in_tag(in_tag),
        .dp_x0(dp_x0), .dp_y0(dp_y0), .dp_xn(dp_xn), .dp_yn(dp_yn),
        .dp_xn1(dp_xn1), .dp_yn1(dp_yn1),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_iter(out_iter),
        .busy(busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        if (e == 255) return b[31] ? -1.0e30 : 1.0e30;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = e - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic        s;
        real         a;
        int          e;
        logic [22:0] m;
        s = (v < 0.0);
        a = s ? -v : v;
        if (a == 0.0) return {s, 31'h0};
        if (!(a < 3.0e38)) return {s, 31'h7F800000};
        e = 0;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        if (e < -126) return {s, 31'h0};
        m = 23'($rtoi((a - 1.0) * 8388608.0));
        return {s, 8'(e + 127), m};
    endfunction

    // Behavioural datapath: z' = z^2 + c, total latency LATENCY counting the dp_* register.
    logic [31:0] pipe_x [LATENCY-1];
    logic [31:0] pipe_y [LATENCY-1];
    always @(posedge clock) begin
        real x, y;
        x = f2r(dp_xn);
        y = f2r(dp_yn);
        pipe_x[0] <= r2f(x * x - y * y + f2r(dp_x0));
        pipe_y[0] <= r2f(2.0 * x * y + f2r(dp_y0));
        for (int i = 1; i < LATENCY - 1; i++) begin
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
        end
    end
    assign dp_xn1 = pipe_x[LATENCY-2];
    assign dp_yn1 = pipe_y[LATENCY-2];

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic offer(input logic [TAG_W-1:0] t, input logic [31:0] x, input logic [31:0] y,
                         input int exp_iter, input bit track);
        bit acc;
        exp_t e;
        in_valid = 1'b1;
        in_tag   = t;
        in_x0    = x;
        in_y0    = y;
        acc      = 1'b0;
        for (int n = 0; n < BUDGET && !acc; n++) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            #1;
        end
        if (acc) begin
            last_acc = cyc;
            if (track) begin
                e.tag  = t;
                e.iter = exp_iter;
                sb.push_back(e);
            end
        end else begin
            check("accept_timeout", 32'(acc), 32'd1);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        int bad;
        int stale;

        // Output monitor: retire handshakes against the scoreboard, check stalled outputs hold.
        fork
            begin
                logic              held;
                logic [TAG_W-1:0]  prev_tag;
                logic [ITER_W-1:0] prev_iter;
                held = 1'b0;
                prev_tag = '0;
                prev_iter = '0;
                forever begin
                    @(negedge clock);
                    if (rst_n && out_valid) begin
                        if (held) begin
                            check("stall_tag", 32'(out_tag), 32'(prev_tag));
                            check("stall_iter", 32'(out_iter), 32'(prev_iter));
                        end
                        if (out_ready) begin
                            int idx;
                            idx = -1;
                            foreach (sb[i]) if (sb[i].tag == out_tag) idx = i;
                            check("tag_expected", 32'(idx >= 0), 32'd1);
                            if (idx >= 0) begin
                                check("iter_count", 32'(out_iter), 32'(sb[idx].iter));
                                sb.delete(idx);
                            end
                            held = 1'b0;
                        end else begin
                            held = 1'b1;
                            prev_tag = out_tag;
                            prev_iter = out_iter;
                        end
                    end else begin
                        held = 1'b0;
                    end
                end
            end
        join_none

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_iter", 32'(out_iter), 32'd0);
        check("rst_dp_x0", dp_x0, 32'd0);
        repeat (3) @(posedge clock);
        #1 rst_n = 1'b1;
        @(posedge clock);
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // c = 2.0 escapes on the first lap
        offer(16'd1, 32'h40000000, 32'h0, 1, 1'b1);
        idle();
        n = 0;
        while (!out_valid && n < 200) begin @(posedge clock); #1; n++; end
        check("latency_k1", 32'(n), 32'(LATENCY));
        wait_drain(200);

        // c = 1.0 escapes on the second lap
        offer(16'd2, 32'h3F800000, 32'h0, 2, 1'b1);
        idle();
        n = 0;
        while (!out_valid && n < 300) begin @(posedge clock); #1; n++; end
        check("latency_k2", 32'(n), 32'(2 * LATENCY));
        wait_drain(200);

        // Bounded orbits hit the cap; others escape after a few laps or via y
        offer(16'd3, 32'h00000000, 32'h0, MAX_ITER, 1'b1);
        offer(16'd4, 32'hBF800000, 32'h0, MAX_ITER, 1'b1);
        offer(16'd5, 32'h3F000000, 32'h0, 5, 1'b1);
        offer(16'd6, 32'h00000000, 32'h40000000, 1, 1'b1);
        offer(16'd7, 32'h00000000, 32'h3F800000, MAX_ITER, 1'b1);
        idle();
        wait_drain(MAX_ITER * LATENCY + 500);

        // 40 escaping pixels back to back
        for (int i = 0; i < 40; i++) begin
            logic [31:0] xv;
            xv = (i % 3 == 0) ? 32'h40000000 : (i % 3 == 1) ? 32'hC0000000 : 32'h40400000;
            offer(16'(100 + i), xv, 32'h0, 1, 1'b1);
            acc_cyc[i] = last_acc;
        end
        idle();
        bad = 0;
        for (int i = 0; i < 30; i++) if (acc_cyc[i] != acc_cyc[0] + i) bad++;
        check("b2b_consecutive", 32'(bad), 32'd0);
        check("b2b_gap", 32'(acc_cyc[30] - acc_cyc[0]), 32'(LATENCY));
        wait_drain(500);
        check("b2b_busy_after", 32'(busy), 32'd0);

        // Back-pressure: results park while the consumer stalls
        out_ready = 1'b0;
        offer(16'd200, 32'h40000000, 32'h0, 1, 1'b1);
        offer(16'd201, 32'h3F800000, 32'h0, 2, 1'b1);
        offer(16'd202, 32'h3F000000, 32'h0, 5, 1'b1);
        idle();
        repeat (200) @(posedge clock);
        #1;
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_pending", 32'(sb.size()), 32'd3);
        out_ready = 1'b1;
        wait_drain(500);
        repeat (2 * LATENCY) @(posedge clock);
        #1;
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // Reset mid-operation drops everything in flight
        for (int i = 0; i < 20; i++) offer(16'(300 + i), 32'h0, 32'h0, MAX_ITER, 1'b0);
        idle();
        repeat (5) @(posedge clock);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1 rst_n = 1'b1;
        @(negedge clock);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        for (int i = 0; i < 2 * LATENCY; i++) begin
            @(negedge clock);
            if (out_valid || busy) stale++;
        end
        check("midrst_stale", 32'(stale), 32'd0);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
